// File: rtl/data_sram_responder_pkg.sv
// cpu_mem_pkg: shared config offsets, region select and byte-merge helper for the data SRAM responder
package cpu_mem_pkg;

    localparam logic [15:0] CONF_LED    = 16'h0000;
    localparam logic [15:0] CONF_SWITCH = 16'h0004;
    localparam logic [15:0] CONF_NUM    = 16'h0008;
    localparam logic [15:0] CONF_TIMER  = 16'h000c;
    localparam logic [15:0] CONF_ERR    = 16'h0010;

    typedef enum logic {REG_RAM, REG_CONF} region_e;

    function automatic logic [31:0] merge_be(logic [31:0] old_word, logic [31:0] new_word, logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: core data SRAM port (request from core, registered read data back)
interface data_sram_responder_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, wen, addr, wdata, input rdata);
    modport slave (input en, wen, addr, wdata, output rdata);

endinterface

// File: rtl/data_sram_responder_byte_lane_ram.sv
// byte_lane_ram: single-port 32-bit RAM with per-byte write enables and a registered read, no reset
module byte_lane_ram
    import cpu_mem_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Writes merge enabled lanes into the word; reads register the word and hold otherwise
    always_ff @(posedge clk) begin
        if (en && we != 4'h0)
            mem[addr] <= merge_be(mem[addr], wdata, we);
        if (en && we == 4'h0)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: decodes core data accesses to on-chip RAM or the config register file
module data_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [15:0] LED_RST   = 16'hffff
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus,
    input  logic [7:0]           switch,
    output logic [15:0]          led,
    output logic [31:0]          num_data,
    output logic                 err
);

    region_e     region;
    region_e     sel_q;
    logic [15:0] off;
    logic        rd;
    logic        conf_wr;
    logic        bad;
    logic        err_clr;
    logic [31:0] conf_rdata;
    logic [31:0] conf_q;
    logic [31:0] ram_q;
    logic [31:0] timer;
    logic [31:0] timer_inc;
    logic [31:0] timer_next;
    logic [15:0] led_next;
    logic [7:0]  sw_q1;
    logic [7:0]  sw_q2;
    logic        unused;

    assign unused = &{1'b0, bus.addr[1:0]};

    // Decode the request and compute next values for the config registers
    always_comb begin
        region     = (bus.addr[31:16] == CONF_BASE[31:16]) ? REG_CONF : REG_RAM;
        off        = {bus.addr[15:2], 2'b00};
        rd         = bus.en && bus.wen == 4'h0;
        conf_wr    = bus.en && bus.wen != 4'h0 && region == REG_CONF;
        bad        = bus.en && region == REG_CONF &&
                     !(off inside {CONF_LED, CONF_SWITCH, CONF_NUM, CONF_TIMER, CONF_ERR});
        conf_rdata = off == CONF_LED    ? {16'h0, led} :
                     off == CONF_SWITCH ? {24'h0, sw_q2} :
                     off == CONF_NUM    ? num_data :
                     off == CONF_TIMER  ? timer :
                     off == CONF_ERR    ? {31'h0, err} : 32'h0;
        led_next   = {bus.wen[1] ? bus.wdata[15:8] : led[15:8], bus.wen[0] ? bus.wdata[7:0] : led[7:0]};
        timer_inc  = timer + 32'd1;
        timer_next = (conf_wr && off == CONF_TIMER) ? merge_be(timer_inc, bus.wdata, bus.wen) : timer_inc;
        err_clr    = conf_wr && off == CONF_ERR && bus.wen[0] && bus.wdata[0];
    end

    // Config registers, free-running timer, switch synchronizer and read-side capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led      <= LED_RST;
            num_data <= 32'h0;
            timer    <= 32'h0;
            err      <= 1'b0;
            sw_q1    <= 8'h0;
            sw_q2    <= 8'h0;
            sel_q    <= REG_CONF;
            conf_q   <= 32'h0;
        end else begin
            sw_q1 <= switch;
            sw_q2 <= sw_q1;
            timer <= timer_next;
            err   <= bad | (err & ~err_clr);
            if (conf_wr && off == CONF_LED)
                led <= led_next;
            if (conf_wr && off == CONF_NUM)
                num_data <= merge_be(num_data, bus.wdata, bus.wen);
            if (rd) begin
                sel_q  <= region;
                conf_q <= conf_rdata;
            end
        end
    end

    byte_lane_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (bus.en && region == REG_RAM),
        .we    (bus.wen),
        .addr  (bus.addr[RAM_AW+1:2]),
        .wdata (bus.wdata),
        .rdata (ram_q)
    );

    assign bus.rdata = (sel_q == REG_RAM) ? ram_q : conf_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed stimulus checked against a transaction-level model every cycle
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  switch = 8'h0;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        err;
    int          tests = 0;
    int          fails = 0;

    data_sram_responder_if bus();

    data_sram_responder dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .switch   (switch),
        .led      (led),
        .num_data (num_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [int];
    logic [31:0] m_rdata;
    logic [31:0] m_num;
    logic [31:0] m_timer;
    logic [31:0] m_tnext;
    logic [15:0] m_led;
    logic        m_err;
    logic [7:0]  m_sw1;
    logic [7:0]  m_sw2;
    logic        m_conf;
    logic [15:0] m_off;
    int          m_idx;

    function automatic logic [31:0] lanes(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rdata = 0; m_led = 16'hffff; m_num = 0; m_timer = 0; m_err = 0; m_sw1 = 0; m_sw2 = 0;
        end else begin
            m_tnext = m_timer + 1;
            if (bus.en) begin
                m_conf = bus.addr[31:16] == 16'hbfaf;
                m_off  = bus.addr[15:0] & 16'hfffc;
                m_idx  = int'(bus.addr[15:2]);
                if (!m_conf && bus.wen == 0) m_rdata = mem.exists(m_idx) ? mem[m_idx] : 32'h0;
                else if (!m_conf) mem[m_idx] = lanes(mem.exists(m_idx) ? mem[m_idx] : 32'h0, bus.wdata, bus.wen);
                else if (bus.wen == 0) begin
                    case (m_off)
                        16'h0:   m_rdata = {16'h0, m_led};
                        16'h4:   m_rdata = {24'h0, m_sw2};
                        16'h8:   m_rdata = m_num;
                        16'hc:   m_rdata = m_timer;
                        16'h10:  m_rdata = {31'h0, m_err};
                        default: begin m_rdata = 0; m_err = 1; end
                    endcase
                end else begin
                    case (m_off)
                        16'h0:   m_led = 16'(lanes({16'h0, m_led}, bus.wdata, {2'b00, bus.wen[1:0]}));
                        16'h4:   ;
                        16'h8:   m_num = lanes(m_num, bus.wdata, bus.wen);
                        16'hc:   m_tnext = lanes(m_tnext, bus.wdata, bus.wen);
                        16'h10:  if (bus.wen[0] && bus.wdata[0]) m_err = 0;
                        default: m_err = 1;
                    endcase
                end
            end
            m_timer = m_tnext;
            m_sw2 = m_sw1;
            m_sw1 = switch;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("cyc_rdata", bus.rdata, m_rdata);
            chk("cyc_led", {16'h0, led}, {16'h0, m_led});
            chk("cyc_num", num_data, m_num);
            chk("cyc_err", {31'h0, err}, {31'h0, m_err});
        end
    end

    task automatic op(logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        bus.en = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0000ffff);
        chk("rst_num", num_data, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        #2 resetn = 1'b1;
        op(1, 4'hf, 32'h1000, 32'h12345678);
        op(1, 4'h0, 32'h1000, 32'h0);
        idle();
        chk("rd_full", bus.rdata, 32'h12345678);
        op(1, 4'hf, 32'h2000, 32'hdeadbeef);
        op(0, 4'hf, 32'h1000, 32'hffffffff);
        idle();
        chk("rd_hold", bus.rdata, 32'h12345678);
        op(1, 4'b0100, 32'h1000, 32'haabbccdd);
        op(1, 4'h0, 32'h1000, 32'h0);
        idle();
        chk("rd_lane2", bus.rdata, 32'h12bb5678);
        op(1, 4'hf, 32'hbfaf000c, 32'hfffffffe);
        idle();
        op(1, 4'h0, 32'hbfaf000c, 32'h0);
        op(1, 4'h0, 32'hbfaf000c, 32'h0);
        chk("timer_max", bus.rdata, 32'hffffffff);
        idle();
        chk("timer_wrap", bus.rdata, 32'h0);
        op(1, 4'hf, 32'hbfaf0008, 32'h11223344);
        op(1, 4'b0010, 32'hbfaf0008, 32'h0000aa00);
        idle();
        chk("num_lane1", num_data, 32'h1122aa44);
        op(1, 4'hf, 32'hbfaf0000, 32'h0);
        idle();
        chk("led_zero", {16'h0, led}, 32'h0);
        op(1, 4'b1100, 32'hbfaf0000, 32'hffffffff);
        op(1, 4'h0, 32'hbfaf0000, 32'h0);
        idle();
        chk("led_upper_ign", bus.rdata, 32'h0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_led", {16'h0, led}, 32'h0000ffff);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        #2 resetn = 1'b1;
        op(1, 4'h0, 32'h1000, 32'h0);
        idle();
        chk("ram_retained", bus.rdata, 32'h12bb5678);
        op(1, 4'h0, 32'hbfaf0020, 32'h0);
        idle();
        chk("bad_rdata", bus.rdata, 32'h0);
        chk("bad_err", {31'h0, err}, 32'h1);
        op(1, 4'h0, 32'hbfaf0010, 32'h0);
        idle();
        chk("err_read", bus.rdata, 32'h1);
        op(1, 4'h1, 32'hbfaf0010, 32'h1);
        idle();
        chk("err_clear", {31'h0, err}, 32'h0);
        op(1, 4'h1, 32'hbfaf0014, 32'h1);
        idle();
        chk("bad_write_err", {31'h0, err}, 32'h1);
        op(1, 4'h1, 32'hbfaf0010, 32'h0);
        idle();
        chk("err_noclr", {31'h0, err}, 32'h1);
        @(negedge clk);
        switch = 8'h5a;
        idle();
        idle();
        op(1, 4'h0, 32'hbfaf0004, 32'h0);
        idle();
        chk("switch_sync", bus.rdata, 32'h0000005a);
        op(1, 4'h0, 32'h00011000, 32'h0);
        idle();
        chk("alias", bus.rdata, 32'h12bb5678);
        op(1, 4'hf, 32'h00012000, 32'h0badf00d);
        op(1, 4'h0, 32'h2000, 32'h0);
        idle();
        chk("alias_write", bus.rdata, 32'h0badf00d);
        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
